// File: rtl/clic_ctrl.sv
// clic_ctrl: core-local interrupt controller. Per-vector edge/level pending, a
// registered priority arbiter, tail chaining and a nested epc/threshold stack.
module clic_ctrl #(
  parameter int          VecSize        = 8,
  parameter int          PrioLevels     = 8,
  parameter int          IMemAddrWidth  = 16,
  parameter logic [11:0] VecCsrBase     = 12'hb00,
  parameter logic [11:0] EntryCsrBase   = 12'hb20,
  parameter logic [11:0] MIntThreshAddr = 12'h347,
  parameter logic [11:0] StackDepthAddr = 12'h350
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     csr_enable,
  input  logic [11:0]              csr_addr,
  input  logic [4:0]               rs1_zimm,
  input  logic [31:0]              rs1_data,
  input  logic [2:0]               csr_op,
  input  logic [VecSize-1:0]       irq_in,
  input  logic [IMemAddrWidth-1:0] pc_in,
  output logic [31:0]              out,
  output logic [IMemAddrWidth-1:0] pc_out,
  output logic                     int_take
);
  localparam int VecWidth  = (VecSize > 1) ? $clog2(VecSize) : 1;
  localparam int PrioWidth = (PrioLevels > 1) ? $clog2(PrioLevels) : 1;
  localparam int AddrW     = IMemAddrWidth - 2;
  localparam int EntW      = 3 + PrioWidth;
  localparam int MaskW     = (AddrW > EntW) ? AddrW : EntW;
  localparam int DepthW    = PrioWidth + 1;

  logic [AddrW-1:0]         vec_q    [VecSize];
  logic [AddrW-1:0]         vec_d    [VecSize];
  logic [PrioWidth-1:0]     prio_q   [VecSize];
  logic [PrioWidth-1:0]     prio_d   [VecSize];
  logic [VecSize-1:0]       pend_q, pend_d, en_q, en_d, edge_q, edge_d, irq_prev_q;
  logic [PrioWidth-1:0]     thresh_q, thresh_d;
  logic [IMemAddrWidth-1:0] stk_pc_q [PrioLevels];
  logic [PrioWidth-1:0]     stk_th_q [PrioLevels];
  logic [DepthW-1:0]        depth_q, depth_d;
  logic                     ovf_q, ovf_d, udf_q, udf_d;
  logic                     arb_valid_q, arb_valid_d;
  logic [VecWidth-1:0]      arb_vec_q, arb_vec_d;
  logic [PrioWidth-1:0]     arb_prio_q, arb_prio_d;

  logic [31:0]          src;
  logic [MaskW-1:0]     wr_set, wr_clr;
  logic [VecSize-1:0]   vec_hit, ent_hit, vec_wr, ent_wr;
  logic                 thr_hit, dep_hit, thr_wr, dep_clr;
  logic [31:0]          ent_rd  [VecSize];
  logic [EntW-1:0]      ent_new [VecSize];
  logic [AddrW-1:0]     vec_new [VecSize];
  logic [PrioWidth-1:0] thr_new, top_idx, push_idx;
  logic                 all_ones, full, empty, tail, take, pop;

  // CSR ops reduce to a set mask and a clear mask applied to each implemented field
  assign src = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;
  always_comb begin
    wr_set = '0;
    wr_clr = '0;
    case (csr_op[1:0])
      2'b01:   begin wr_set = src[MaskW-1:0]; wr_clr = '1; end
      2'b10:   wr_set = src[MaskW-1:0];
      2'b11:   wr_clr = src[MaskW-1:0];
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < VecSize; gi++) begin : g_vec
      assign vec_hit[gi] = (csr_addr == VecCsrBase + 12'(gi));
      assign ent_hit[gi] = (csr_addr == EntryCsrBase + 12'(gi));
      assign ent_rd[gi]  = 32'({prio_q[gi], edge_q[gi], en_q[gi], pend_q[gi]});
      assign ent_new[gi] = (ent_rd[gi][EntW-1:0] & ~wr_clr[EntW-1:0]) | wr_set[EntW-1:0];
      assign vec_new[gi] = (vec_q[gi] & ~wr_clr[AddrW-1:0]) | wr_set[AddrW-1:0];
    end
  endgenerate

  assign thr_hit = (csr_addr == MIntThreshAddr);
  assign dep_hit = (csr_addr == StackDepthAddr);
  assign vec_wr  = {VecSize{csr_enable}} & vec_hit;
  assign ent_wr  = {VecSize{csr_enable}} & ent_hit;
  assign thr_wr  = csr_enable & thr_hit;
  assign dep_clr = csr_enable & dep_hit & (csr_op[1:0] == 2'b01) & (src == '0);
  assign thr_new = (thresh_q & ~wr_clr[PrioWidth-1:0]) | wr_set[PrioWidth-1:0];

  assign all_ones = &pc_in;
  assign full     = (depth_q == DepthW'(PrioLevels));
  assign empty    = (depth_q == '0);
  assign top_idx  = PrioWidth'(depth_q - DepthW'(1));
  assign push_idx = PrioWidth'(depth_q);
  assign tail     = all_ones & arb_valid_q;
  assign take     = ~all_ones & arb_valid_q & ~full;
  assign pop      = all_ones & ~arb_valid_q & ~empty;
  assign int_take = tail | take;

  always_comb begin
    pc_out = pc_in;
    if (int_take)
      pc_out = {vec_q[arb_vec_q], 2'b00};
    else if (pop)
      pc_out = stk_pc_q[top_idx];
  end

  // Highest priority above threshold wins; strict compare keeps the lowest index on ties
  always_comb begin
    arb_valid_d = 1'b0;
    arb_vec_d   = '0;
    arb_prio_d  = '0;
    for (int k = 0; k < VecSize; k++) begin
      if (pend_q[k] && en_q[k] && (prio_q[k] > thresh_q) &&
          (!arb_valid_d || (prio_q[k] > arb_prio_d))) begin
        arb_valid_d = 1'b1;
        arb_vec_d   = VecWidth'(k);
        arb_prio_d  = prio_q[k];
      end
    end
    if (int_take || pop || thr_wr || (|ent_wr))
      arb_valid_d = 1'b0;
  end

  always_comb begin
    vec_d  = vec_q;
    prio_d = prio_q;
    en_d   = en_q;
    edge_d = edge_q;
    pend_d = pend_q;
    for (int k = 0; k < VecSize; k++) begin
      if (vec_wr[k]) vec_d[k] = vec_new[k];
      if (ent_wr[k]) begin
        prio_d[k] = ent_new[k][EntW-1:3];
        edge_d[k] = ent_new[k][2];
        en_d[k]   = ent_new[k][1];
        pend_d[k] = ent_new[k][0];
      end
      if (int_take && (arb_vec_q == VecWidth'(k))) pend_d[k] = 1'b0;
      // hardware pend has the last word over both software clear and take clear
      if (edge_q[k] ? (irq_in[k] & ~irq_prev_q[k]) : irq_in[k]) pend_d[k] = 1'b1;
    end
    thresh_d = thr_wr ? thr_new : thresh_q;
    depth_d  = depth_q;
    if (take) begin
      thresh_d = arb_prio_q;
      depth_d  = depth_q + DepthW'(1);
    end else if (pop) begin
      thresh_d = stk_th_q[top_idx];
      depth_d  = depth_q - DepthW'(1);
    end
    ovf_d = dep_clr ? 1'b0 : ovf_q;
    udf_d = dep_clr ? 1'b0 : udf_q;
    if (~all_ones & arb_valid_q & full) ovf_d = 1'b1;
    if (all_ones & ~arb_valid_q & empty) udf_d = 1'b1;
  end

  always_comb begin
    out = '0;
    for (int k = 0; k < VecSize; k++) begin
      if (vec_hit[k]) out = 32'(vec_q[k]);
      if (ent_hit[k]) out = ent_rd[k];
    end
    if (thr_hit) out = 32'(thresh_q);
    if (dep_hit) out = 32'({udf_q, ovf_q, depth_q});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < VecSize; k++) begin
        vec_q[k]  <= '0;
        prio_q[k] <= '0;
      end
      for (int s = 0; s < PrioLevels; s++) begin
        stk_pc_q[s] <= '0;
        stk_th_q[s] <= '0;
      end
      pend_q      <= '0;
      en_q        <= '0;
      edge_q      <= '0;
      irq_prev_q  <= '0;
      thresh_q    <= '0;
      depth_q     <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      arb_valid_q <= 1'b0;
      arb_vec_q   <= '0;
      arb_prio_q  <= '0;
    end else begin
      vec_q       <= vec_d;
      prio_q      <= prio_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      edge_q      <= edge_d;
      irq_prev_q  <= irq_in;
      thresh_q    <= thresh_d;
      depth_q     <= depth_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      arb_valid_q <= arb_valid_d;
      arb_vec_q   <= arb_vec_d;
      arb_prio_q  <= arb_prio_d;
      if (take) begin
        stk_pc_q[push_idx] <= pc_in;
        stk_th_q[push_idx] <= thresh_q;
      end
    end
  end
endmodule

// File: tb/tb_clic_ctrl.sv
// tb_clic_ctrl: table-driven CSR vectors plus hand-written interrupt sequences;
// expectations are queued as stimulus is applied and compared as outputs appear.
module tb_clic_ctrl;
  localparam int          AW  = 16;
  localparam logic [11:0] VEC = 12'hb00;
  localparam logic [11:0] ENT = 12'hb20;
  localparam logic [11:0] THR = 12'h347;
  localparam logic [11:0] DEP = 12'h350;
  localparam logic [2:0]  RW  = 3'b001, RS = 3'b010, RC = 3'b011;
  localparam logic [2:0]  RSI = 3'b110, RCI = 3'b111;
  localparam logic [AW-1:0] RET = '1;

  logic          clk = 1'b0, reset = 1'b0, csr_enable = 1'b0, int_take;
  logic [11:0]   csr_addr = '0;
  logic [4:0]    rs1_zimm = '0;
  logic [31:0]   rs1_data = '0, out;
  logic [2:0]    csr_op = '0;
  logic [7:0]    irq_in = '0;
  logic [AW-1:0] pc_in = 16'h200, pc_out;

  clic_ctrl #(.VecSize(8), .PrioLevels(8), .IMemAddrWidth(AW)) dut (
    .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
    .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .csr_op(csr_op), .irq_in(irq_in),
    .pc_in(pc_in), .out(out), .pc_out(pc_out), .int_take(int_take));

  always #5 clk = ~clk;

  typedef struct { string name; logic [31:0] val; } exp_t;
  typedef struct { logic [11:0] addr; logic [2:0] op; logic [31:0] data; logic [31:0] exp; } vec_t;
  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;

  task automatic expect_val(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] act);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
      end else
        $display("ok   %s = %h", e.name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
    csr_enable = 1'b1;
    csr_addr   = a;
    csr_op     = op;
    rs1_data   = d;
    rs1_zimm   = d[4:0];
    tick();
    csr_enable = 1'b0;
  endtask

  task automatic check_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
    expect_val(name, exp);
    csr_addr = a;
    #1;
    observe(out);
  endtask

  task automatic outs(input string tag, input logic exp_take, input logic [AW-1:0] exp_pc);
    expect_val({tag, "_take"}, 32'(exp_take));
    expect_val({tag, "_pc"}, 32'(exp_pc));
    #1;
    observe(32'(int_take));
    observe(32'(pc_out));
  endtask

  task automatic wait_take(output logic got);
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (int_take) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    irq_in     = '0;
    pc_in      = 16'h200;
    csr_enable = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  vec_t tbl[13];
  logic got;

  initial begin
    tbl[0]  = '{VEC + 12'd3, RW,  32'h40,       32'h40};
    tbl[1]  = '{VEC + 12'd3, RS,  32'h3,        32'h43};
    tbl[2]  = '{VEC + 12'd3, RC,  32'h1,        32'h42};
    tbl[3]  = '{VEC + 12'd0, RW,  32'hFFFFFFFF, 32'h3FFF};
    tbl[4]  = '{VEC + 12'd0, RCI, 32'h1F,       32'h3FE0};
    tbl[5]  = '{ENT + 12'd2, RW,  32'h3,        32'h03};
    tbl[6]  = '{ENT + 12'd2, RC,  32'h1,        32'h02};
    tbl[7]  = '{ENT + 12'd5, RW,  32'hF8,       32'h38};
    tbl[8]  = '{THR,         RW,  32'hFF,       32'h07};
    tbl[9]  = '{THR,         RCI, 32'h05,       32'h02};
    tbl[10] = '{ENT + 12'd5, RSI, 32'h04,       32'h3C};
    tbl[11] = '{12'h123,     RW,  32'h55,       32'h00};
    tbl[12] = '{DEP,         RW,  32'h7,        32'h00};

    // reset state
    do_reset();
    outs("rst", 1'b0, 16'h200);
    check_csr("rst_depth", DEP, 32'h0);
    check_csr("rst_thresh", THR, 32'h0);
    check_csr("rst_vec3", VEC + 12'd3, 32'h0);
    check_csr("rst_ent3", ENT + 12'd3, 32'h0);

    // CSR read/write vectors
    for (int i = 0; i < 13; i++) begin
      expect_val($sformatf("tbl%0d_%h", i, tbl[i].addr), tbl[i].exp);
      csr_wr(tbl[i].addr, tbl[i].op, tbl[i].data);
      csr_addr = tbl[i].addr;
      #1;
      observe(out);
    end
    outs("tbl_idle", 1'b0, 16'h200);

    // single edge interrupt on vec3
    do_reset();
    csr_wr(VEC + 12'd3, RW, 32'h40);
    csr_wr(ENT + 12'd3, RW, 32'h16);
    irq_in[3] = 1'b1;
    outs("s1_c0", 1'b0, 16'h200);
    tick();
    outs("s1_c1", 1'b0, 16'h200);
    check_csr("s1_pend", ENT + 12'd3, 32'h17);
    tick();
    outs("s1_c2", 1'b1, 16'h100);
    tick();
    outs("s1_c3", 1'b0, 16'h200);
    check_csr("s1_thresh", THR, 32'h2);
    check_csr("s1_depth", DEP, 32'h1);
    check_csr("s1_ent3", ENT + 12'd3, 32'h16);
    irq_in[3] = 1'b0;

    // nesting and two returns
    do_reset();
    csr_wr(VEC + 12'd1, RW, 32'h10);
    csr_wr(ENT + 12'd1, RW, 32'h0E);
    csr_wr(VEC + 12'd5, RW, 32'h20);
    csr_wr(ENT + 12'd5, RW, 32'h26);
    irq_in[1] = 1'b1;
    tick();
    irq_in[1] = 1'b0;
    tick();
    outs("n_take1", 1'b1, 16'h40);
    tick();
    pc_in = 16'h44;
    irq_in[5] = 1'b1;
    tick();
    irq_in[5] = 1'b0;
    tick();
    outs("n_take2", 1'b1, 16'h80);
    tick();
    check_csr("n_depth2", DEP, 32'h2);
    check_csr("n_thresh4", THR, 32'h4);
    pc_in = RET;
    outs("n_ret1", 1'b0, 16'h44);
    tick();
    outs("n_ret2", 1'b0, 16'h200);
    check_csr("n_thresh1", THR, 32'h1);
    check_csr("n_depth1", DEP, 32'h1);
    tick();
    pc_in = 16'h204;
    check_csr("n_thresh0", THR, 32'h0);
    check_csr("n_depth0", DEP, 32'h0);
    outs("n_idle", 1'b0, 16'h204);

    // tail chain: vec6 becomes valid exactly in the return cycle
    do_reset();
    csr_wr(VEC + 12'd2, RW, 32'h30);
    csr_wr(ENT + 12'd2, RW, 32'h1E);
    csr_wr(VEC + 12'd6, RW, 32'h50);
    csr_wr(ENT + 12'd6, RW, 32'h2E);
    irq_in[2] = 1'b1;
    tick();
    irq_in[2] = 1'b0;
    tick();
    outs("t_take", 1'b1, 16'hC0);
    tick();
    pc_in = 16'h300;
    irq_in[6] = 1'b1;
    tick();
    irq_in[6] = 1'b0;
    outs("t_wait", 1'b0, 16'h300);
    tick();
    pc_in = RET;
    outs("t_chain", 1'b1, 16'h140);
    tick();
    pc_in = 16'h300;
    outs("t_after", 1'b0, 16'h300);
    check_csr("t_depth", DEP, 32'h1);
    check_csr("t_thresh", THR, 32'h3);
    check_csr("t_ent6", ENT + 12'd6, 32'h2E);

    // tie, threshold blocking, level re-pend
    do_reset();
    csr_wr(VEC + 12'd0, RW, 32'h8);
    csr_wr(VEC + 12'd4, RW, 32'h18);
    csr_wr(THR, RW, 32'h5);
    csr_wr(ENT + 12'd0, RW, 32'h2B);
    csr_wr(ENT + 12'd4, RW, 32'h2B);
    for (int c = 0; c < 3; c++) begin
      outs($sformatf("thr5_c%0d", c), 1'b0, 16'h200);
      tick();
    end
    csr_wr(THR, RW, 32'h0);
    outs("tie_c1", 1'b0, 16'h200);
    tick();
    outs("tie_take", 1'b1, 16'h20);
    tick();
    outs("tie_after", 1'b0, 16'h200);
    check_csr("tie_ent0", ENT + 12'd0, 32'h2A);
    check_csr("tie_ent4", ENT + 12'd4, 32'h2B);
    check_csr("tie_thresh", THR, 32'h5);
    csr_wr(VEC + 12'd7, RW, 32'h70);
    csr_wr(ENT + 12'd7, RW, 32'h32);
    irq_in[7] = 1'b1;
    tick();
    tick();
    outs("lvl_take", 1'b1, 16'h1C0);
    tick();
    check_csr("lvl_repend", ENT + 12'd7, 32'h33);
    check_csr("lvl_thresh", THR, 32'h6);
    irq_in[7] = 1'b0;

    // underflow, overflow, status clear
    do_reset();
    pc_in = RET;
    outs("udf", 1'b0, RET);
    tick();
    pc_in = 16'h200;
    check_csr("udf_bit", DEP, 32'h20);
    csr_wr(VEC + 12'd1, RW, 32'h10);
    csr_wr(ENT + 12'd1, RW, 32'h0A);
    irq_in[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_take(got);
      expect_val($sformatf("ovf_fill%0d", i), 32'h1);
      observe(32'(got));
      tick();
      csr_wr(THR, RW, 32'h0);
    end
    for (int c = 0; c < 4; c++) begin
      outs($sformatf("ovf_none%0d", c), 1'b0, 16'h200);
      tick();
    end
    check_csr("ovf_bits", DEP, 32'h38);
    csr_wr(THR, RW, 32'h7);
    tick();
    csr_wr(DEP, RW, 32'h0);
    check_csr("clr_bits", DEP, 32'h08);
    irq_in[1] = 1'b0;

    // asynchronous reset in the take cycle
    do_reset();
    csr_wr(VEC + 12'd3, RW, 32'h40);
    csr_wr(ENT + 12'd3, RW, 32'h16);
    irq_in[3] = 1'b1;
    tick();
    tick();
    outs("ar_take", 1'b1, 16'h100);
    reset = 1'b0;
    outs("ar_rst", 1'b0, 16'h200);
    check_csr("ar_depth", DEP, 32'h0);
    check_csr("ar_thresh", THR, 32'h0);
    check_csr("ar_ent3", ENT + 12'd3, 32'h0);
    check_csr("ar_vec3", VEC + 12'd3, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      outs($sformatf("ar_quiet%0d", c), 1'b0, 16'h200);
      tick();
    end
    check_csr("ar_depth_end", DEP, 32'h0);
    irq_in[3] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
